stream_checker: RTL and testbench

Receiving end of the valid/ready byte stream. It sits at the far side of a handshake bridge and accepts beats under a pseudo-random ready pattern supplied from outside. Each accepted beat is checked against an incrementing reference sequence, and the block counts accepted beats and mismatches. It raises `done_o` after a programmed number of beats, so self-checking benches and on-chip BIST use one synthesizable sink instead of separate behavioural receiver and scoreboard code.

---
 rtl/stream_checker.sv | 146 ++++++++++++++
 tb/tb_stream_checker.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/stream_checker.sv
// stream_checker: valid/ready byte-stream sink that checks accepted beats
// against an incrementing reference sequence, counts beats and mismatches,
// and raises done_o after TARGET accepted beats.
// Optional protocol monitor: define STREAM_CHECKER_PROTO_CHK_EN to compile it in.
module stream_checker #(
  parameter int DATA_W    = 8,
  parameter int START_VAL = 1,
  parameter int TARGET    = 200,
  parameter int CNT_W     = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start_i,
  input  logic              valid_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic              random_ready,
  output logic              ready_o,
  output logic [DATA_W-1:0] expect_o,
  output logic [CNT_W-1:0]  beat_cnt_o,
  output logic [CNT_W-1:0]  err_cnt_o,
  output logic              seq_err_o,
  output logic              proto_err_o,
  output logic              done_o
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  localparam logic [CNT_W-1:0]  TARGET_C = CNT_W'(TARGET);
  localparam logic [DATA_W-1:0] START_C  = DATA_W'(START_VAL);

  state_t              state_q, state_d;
  logic                ready_q, ready_d;
  logic [DATA_W-1:0]   expect_q, expect_d;
  logic [CNT_W-1:0]    beat_q, beat_d;
  logic [CNT_W-1:0]    err_q, err_d;
  logic                seq_q, seq_d;
  logic                accept;

  // ready_q can only be 1 in RUN, so this is the whole acceptance condition
  assign accept = valid_i & ready_q;

  // Next-state, counter and reference-sequence logic
  always_comb begin
    state_d  = state_q;
    beat_d   = beat_q;
    err_d    = err_q;
    expect_d = expect_q;
    seq_d    = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start_i) begin
          state_d  = S_RUN;
          beat_d   = '0;
          err_d    = '0;
          expect_d = START_C;
        end
      end
      S_RUN: begin
        if (accept) begin
          beat_d   = beat_q + 1'b1;
          expect_d = expect_q + 1'b1;
          if (data_i != expect_q) begin
            seq_d = 1'b1;
            if (err_q != '1) err_d = err_q + 1'b1;
          end
          if (beat_d == TARGET_C) state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (start_i) begin
          state_d  = S_RUN;
          beat_d   = '0;
          err_d    = '0;
          expect_d = START_C;
        end
      end
      default: state_d = S_IDLE;
    endcase
    ready_d = (state_d == S_RUN) ? random_ready : 1'b0;
  end

  // State and datapath registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      ready_q  <= 1'b0;
      expect_q <= START_C;
      beat_q   <= '0;
      err_q    <= '0;
      seq_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      ready_q  <= ready_d;
      expect_q <= expect_d;
      beat_q   <= beat_d;
      err_q    <= err_d;
      seq_q    <= seq_d;
    end
  end

  assign ready_o    = ready_q;
  assign expect_o   = expect_q;
  assign beat_cnt_o = beat_q;
  assign err_cnt_o  = err_q;
  assign seq_err_o  = seq_q;
  assign done_o     = (state_q == S_DONE);

`ifdef STREAM_CHECKER_PROTO_CHK_EN
  logic              pend_q, pend_d;
  logic [DATA_W-1:0] cap_q;
  logic              proto_q, proto_d;
  logic              restart;

  assign restart = (state_q == S_DONE) & start_i;

  // Protocol monitor: a stalled beat must keep valid and data stable
  always_comb begin
    pend_d  = (state_q == S_RUN) & valid_i & ~ready_q;
    proto_d = proto_q;
    if (restart) begin
      proto_d = 1'b0;
    end else if ((state_q == S_RUN) && pend_q &&
                 (!valid_i || (data_i != cap_q))) begin
      proto_d = 1'b1;
    end
  end

  // Monitor registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pend_q  <= 1'b0;
      cap_q   <= '0;
      proto_q <= 1'b0;
    end else begin
      pend_q  <= pend_d;
      proto_q <= proto_d;
      if (pend_d) cap_q <= data_i;
    end
  end

  assign proto_err_o = proto_q;
`else
  assign proto_err_o = 1'b0;
`endif

endmodule

// File: tb/tb_stream_checker.sv
// Directed bench for stream_checker: default instance for the main tests,
// a second instance (START_VAL=250, TARGET=300) for the data wrap test.
module tb_stream_checker;

  logic        clk = 1'b0;
  logic        reset = 1'b1;

  logic        start, valid, rdy;
  logic [7:0]  data;
  logic        ready_o, seq_err_o, proto_err_o, done_o;
  logic [7:0]  expect_o;
  logic [15:0] beat_cnt_o, err_cnt_o;

  logic        b_start, b_valid, b_rdy;
  logic [7:0]  b_data;
  logic        b_ready_o, b_seq_err_o, b_proto_err_o, b_done_o;
  logic [7:0]  b_expect_o;
  logic [15:0] b_beat_cnt_o, b_err_cnt_o;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  stream_checker #(.DATA_W(8), .START_VAL(1), .TARGET(200), .CNT_W(16)) dut (
    .clk(clk), .reset(reset), .start_i(start), .valid_i(valid), .data_i(data),
    .random_ready(rdy), .ready_o(ready_o), .expect_o(expect_o),
    .beat_cnt_o(beat_cnt_o), .err_cnt_o(err_cnt_o), .seq_err_o(seq_err_o),
    .proto_err_o(proto_err_o), .done_o(done_o)
  );

  stream_checker #(.DATA_W(8), .START_VAL(250), .TARGET(300), .CNT_W(16)) dut_wrap (
    .clk(clk), .reset(reset), .start_i(b_start), .valid_i(b_valid), .data_i(b_data),
    .random_ready(b_rdy), .ready_o(b_ready_o), .expect_o(b_expect_o),
    .beat_cnt_o(b_beat_cnt_o), .err_cnt_o(b_err_cnt_o), .seq_err_o(b_seq_err_o),
    .proto_err_o(b_proto_err_o), .done_o(b_done_o)
  );

  typedef struct {
    logic       valid;
    logic [7:0] data;
    logic       rdy;
    int         beat;
    int         err;
    logic       seq;
    int         expv;
    logic       ready;
  } vec_t;

  vec_t vecs[8];

`ifdef STREAM_CHECKER_PROTO_CHK_EN
  localparam logic PROTO_EXP = 1'b1;
`else
  localparam logic PROTO_EXP = 1'b0;
`endif

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic vld, rm, acc, seq_seen;
    int cnt, cyc;

    start = 0; valid = 0; rdy = 0; data = 0;
    b_start = 0; b_valid = 0; b_rdy = 0; b_data = 0;

    vecs[0] = '{1'b1, 8'd1, 1'b1, 1, 0, 1'b0, 2, 1'b1};
    vecs[1] = '{1'b1, 8'd2, 1'b0, 2, 0, 1'b0, 3, 1'b0};
    vecs[2] = '{1'b1, 8'd9, 1'b1, 2, 0, 1'b0, 3, 1'b1};
    vecs[3] = '{1'b1, 8'd9, 1'b1, 3, 1, 1'b1, 4, 1'b1};
    vecs[4] = '{1'b0, 8'd0, 1'b1, 3, 1, 1'b0, 4, 1'b1};
    vecs[5] = '{1'b1, 8'd4, 1'b1, 4, 1, 1'b0, 5, 1'b1};
    vecs[6] = '{1'b1, 8'd5, 1'b1, 5, 1, 1'b0, 6, 1'b1};
    vecs[7] = '{1'b0, 8'd0, 1'b0, 5, 1, 1'b0, 6, 1'b0};

    step(); step();
    reset = 0;
    check("rst_ready", ready_o, 0);
    check("rst_beat", beat_cnt_o, 0);
    check("rst_err", err_cnt_o, 0);
    check("rst_expect", expect_o, 1);
    check("rst_done", done_o, 0);
    check("rst_seq", seq_err_o, 0);

    // Test 1: continuous stream 1..200
    start = 1; rdy = 1; valid = 1; data = 8'd1;
    step();
    start = 0;
    check("t1_start_beat", beat_cnt_o, 0);
    check("t1_start_ready", ready_o, 1);
    for (int k = 1; k <= 200; k++) begin
      step();
      check("t1_beat", beat_cnt_o, k);
      if (k == 199) check("t1_done_early", done_o, 0);
      data = 8'(k + 1);
    end
    check("t1_done", done_o, 1);
    check("t1_expect", expect_o, 201);
    check("t1_err", err_cnt_o, 0);
    check("t1_ready_done", ready_o, 0);
    step();
    check("t1_no_extra_beat", beat_cnt_o, 200);
    check("t1_ready_hold", ready_o, 0);

    // Test 2: restart with valid=1 and ready_o=0, then random handshake
    start = 1; valid = 1; data = 8'd1; rdy = 1'($urandom_range(0, 1));
    rm = rdy;
    step();
    start = 0;
    check("t2_restart_beat", beat_cnt_o, 0);
    check("t2_restart_expect", expect_o, 1);
    check("t2_restart_done", done_o, 0);
    vld = 1; cnt = 0; cyc = 0; seq_seen = 0;
    while (cnt < 200 && cyc < 5000) begin
      rdy = 1'($urandom_range(0, 1));
      step();
      cyc++;
      acc = vld && rm;
      if (acc) cnt++;
      rm = (cnt < 200) ? rdy : 1'b0;
      if (seq_err_o) seq_seen = 1;
      if (acc || !vld) begin
        vld = 1'($urandom_range(0, 1));
        data = 8'(1 + cnt);
      end
      valid = vld;
    end
    check("t2_timeout", (cyc < 5000), 1);
    check("t2_beat", beat_cnt_o, 200);
    check("t2_err", err_cnt_o, 0);
    check("t2_seq_never", seq_seen, 0);
    check("t2_done", done_o, 1);
    check("t2_proto_clean", proto_err_o, 0);

    // Test 3: table-driven 1,2,9,4,5
    valid = 0; start = 1; rdy = 1;
    step();
    start = 0;
    check("t3_restart_beat", beat_cnt_o, 0);
    check("t3_restart_ready", ready_o, 1);
    for (int i = 0; i < 8; i++) begin
      valid = vecs[i].valid; data = vecs[i].data; rdy = vecs[i].rdy;
      step();
      check($sformatf("t3_v%0d_beat", i), beat_cnt_o, vecs[i].beat);
      check($sformatf("t3_v%0d_err", i), err_cnt_o, vecs[i].err);
      check($sformatf("t3_v%0d_seq", i), seq_err_o, vecs[i].seq);
      check($sformatf("t3_v%0d_expect", i), expect_o, vecs[i].expv);
      check($sformatf("t3_v%0d_ready", i), ready_o, vecs[i].ready);
    end

    // Test 4: stalled beat, then valid dropped
    valid = 1; data = 8'd6; rdy = 0;
    step();
    check("t4_no_accept", beat_cnt_o, 5);
    check("t4_proto_pre", proto_err_o, 0);
    valid = 0;
    step();
    check("t4_proto_set", proto_err_o, PROTO_EXP);
    step(); step();
    check("t4_proto_sticky", proto_err_o, PROTO_EXP);

    // Test 5: run to 57 beats, then asynchronous reset
    rdy = 1; valid = 0;
    step();
    cnt = 5;
    valid = 1;
    while (cnt < 57) begin
      data = 8'(cnt + 1);
      step();
      cnt++;
    end
    check("t5_beat57", beat_cnt_o, 57);
    check("t5_expect58", expect_o, 58);
    check("t5_err1", err_cnt_o, 1);
    data = 8'd58;
    #2 reset = 1;
    #1;
    check("t5_async_ready", ready_o, 0);
    check("t5_async_beat", beat_cnt_o, 0);
    check("t5_async_err", err_cnt_o, 0);
    check("t5_async_expect", expect_o, 1);
    check("t5_async_proto", proto_err_o, 0);
    check("t5_async_done", done_o, 0);
    check("t5_async_seq", seq_err_o, 0);
    step();
    reset = 0;
    check("t5_held_beat", beat_cnt_o, 0);
    valid = 0; start = 1; rdy = 1;
    step();
    start = 0;
    check("t5_restart_beat", beat_cnt_o, 0);
    check("t5_restart_expect", expect_o, 1);
    valid = 1; data = 8'd1;
    step();
    data = 8'd2;
    step();
    valid = 0;
    check("t5_recount_beat", beat_cnt_o, 2);
    check("t5_recount_err", err_cnt_o, 0);
    check("t5_recount_expect", expect_o, 3);

    // Test 6: wrap instance, 250..255,0,1,...
    b_start = 1; b_rdy = 1; b_valid = 1; b_data = 8'd250;
    step();
    b_start = 0;
    seq_seen = 0;
    for (int k = 1; k <= 300; k++) begin
      step();
      if (b_seq_err_o) seq_seen = 1;
      if (k == 299) check("t6_done_early", b_done_o, 0);
      b_data = b_data + 8'd1;
    end
    check("t6_beat", b_beat_cnt_o, 300);
    check("t6_err", b_err_cnt_o, 0);
    check("t6_seq_never", seq_seen, 0);
    check("t6_expect", b_expect_o, 38);
    check("t6_done", b_done_o, 1);
    check("t6_ready", b_ready_o, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
